// File: rtl/npu_seq_pkg.sv
// Shared types and constants for the NPU host sequencer: state encoding,
// host address decode codes and the buffer-write payload.
package npu_seq_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned IDX_W  = 12;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CH_WAIT   = 4'd1,
    ST_CONV1     = 4'd2,
    ST_RELOAD    = 4'd3,
    ST_CONV2     = 4'd4,
    ST_FC_START  = 4'd5,
    ST_FC_STREAM = 4'd6,
    ST_FC_RUN    = 4'd7
  } state_t;

  localparam int unsigned CTRL_GO      = 0;
  localparam int unsigned CTRL_ABORT   = 1;
  localparam int unsigned CTRL_CLR     = 2;
  localparam int unsigned CTRL_NEW_INF = 3;

  localparam logic [SEL_W-1:0] SEL_IMG  = 3'd1;
  localparam logic [SEL_W-1:0] SEL_WC   = 3'd2;
  localparam logic [SEL_W-1:0] SEL_FC1  = 3'd3;
  localparam logic [SEL_W-1:0] SEL_FC2  = 3'd4;
  localparam logic [SEL_W-1:0] SEL_CTRL = 3'd5;
  localparam logic [SEL_W-1:0] SEL_STAT = 3'd7;

  localparam logic [IDX_W-1:0] IDX_STATUS  = 12'd0;
  localparam logic [IDX_W-1:0] IDX_LOGIT   = 12'd4;
  localparam logic [IDX_W-1:0] IDX_CNT     = 12'd8;
  localparam logic [IDX_W-1:0] IDX_VERSION = 12'd12;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } buf_wr_t;

  function automatic logic is_buf_sel(input logic [SEL_W-1:0] sel);
    return (sel == SEL_IMG) || (sel == SEL_WC) || (sel == SEL_FC2);
  endfunction

  // States in which a compute engine owns the data buffers.
  function automatic logic is_busy(input state_t st);
    return (st == ST_CONV1) || (st == ST_CONV2) || (st == ST_FC_RUN);
  endfunction

endpackage

// File: rtl/npu_seq_regs.sv
// Host register port: write decode and forwarding, control strobes,
// sticky status bits and the registered 1-cycle read mux.
module npu_seq_regs
  import npu_seq_pkg::*;
#(
  parameter int unsigned CH_W    = 4,
  parameter int unsigned GRP_W   = 6,
  parameter int unsigned RES_W   = 24,
  parameter logic [7:0]  VERSION = 8'h02
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ena,
  input  logic              i_wea,
  input  logic [ADDR_W-1:0] i_addra,
  input  logic [DATA_W-1:0] i_dina,
  input  state_t            i_state,
  input  logic [CH_W-1:0]   i_ch_cnt,
  input  logic [GRP_W-1:0]  i_grp_cnt,
  input  logic [RES_W-1:0]  i_logit,
  input  logic              i_fc_w_ready,
  input  logic              i_done_set,
  input  logic              i_err_early,
  output logic [DATA_W-1:0] o_douta,
  output logic              o_buf_we,
  output logic [SEL_W-1:0]  o_buf_sel,
  output logic [IDX_W-1:0]  o_buf_idx,
  output logic [DATA_W-1:0] o_buf_data,
  output logic              o_fc_w_valid,
  output logic              o_irq,
  output logic              o_go_c,
  output logic              o_abort_c,
  output logic              o_new_inf_c,
  output logic              o_fc_acc_c
);

  logic [SEL_W-1:0]  w_sel;
  logic [IDX_W-1:0]  w_idx;
  logic              w_wr, w_rd, w_ctrl_wr, w_clr;
  logic              w_buf_wr, w_busy, w_fc1_wr, w_fc_ok, w_fc_acc;
  logic              w_fc_need_w, w_stat_rd;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused;

  buf_wr_t r_buf;
  logic    r_done, r_err_busy, r_err_wr;

  assign w_sel     = i_addra[14:12];
  assign w_idx     = i_addra[11:0];
  assign w_unused  = i_addra[15];
  assign w_wr      = i_ena & i_wea;
  assign w_rd      = i_ena & ~i_wea;
  assign w_ctrl_wr = w_wr && (w_sel == SEL_CTRL);
  assign w_clr     = w_ctrl_wr & i_dina[CTRL_CLR];

  assign o_go_c      = w_ctrl_wr & i_dina[CTRL_GO];
  assign o_abort_c   = w_ctrl_wr & i_dina[CTRL_ABORT];
  assign o_new_inf_c = w_ctrl_wr & i_dina[CTRL_NEW_INF];

  assign w_buf_wr    = w_wr && is_buf_sel(w_sel);
  assign w_busy      = is_busy(i_state);
  assign w_fc1_wr    = w_wr && (w_sel == SEL_FC1);
  assign w_fc_ok     = (i_state == ST_FC_STREAM) && i_fc_w_ready;
  assign w_fc_acc    = w_fc1_wr & w_fc_ok;
  assign o_fc_acc_c  = w_fc_acc;
  assign w_fc_need_w = w_fc_ok;
  assign w_stat_rd   = w_rd && (w_sel == SEL_STAT) && (w_idx == IDX_STATUS);

  // Read mux; anything outside the status page reads as zero.
  always_comb begin
    w_rdata = '0;
    if (w_sel == SEL_STAT) begin
      case (w_idx)
        IDX_STATUS:  w_rdata = {16'h0000, VERSION, 4'(i_state), w_fc_need_w,
                                r_err_wr, r_err_busy, r_done};
        IDX_LOGIT:   w_rdata = {{(DATA_W-RES_W){i_logit[RES_W-1]}}, i_logit};
        IDX_CNT:     w_rdata = DATA_W'({i_ch_cnt, i_grp_cnt});
        IDX_VERSION: w_rdata = DATA_W'(VERSION);
        default:     w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_douta      <= '0;
      o_buf_we     <= 1'b0;
      o_fc_w_valid <= 1'b0;
      r_buf        <= '0;
      r_done       <= 1'b0;
      r_err_busy   <= 1'b0;
      r_err_wr     <= 1'b0;
    end else begin
      o_buf_we     <= 1'b0;
      o_fc_w_valid <= 1'b0;
      if (w_rd) o_douta <= w_rdata;
      if (w_buf_wr && !w_busy) begin
        o_buf_we <= 1'b1;
        r_buf    <= '{sel: w_sel, idx: w_idx, data: i_dina};
      end
      if (w_fc_acc) begin
        o_fc_w_valid <= 1'b1;
        r_buf        <= '{sel: w_sel, idx: w_idx, data: i_dina};
      end
      // Sticky bits: a same-cycle set always beats a clear.
      if (w_clr) begin
        r_err_busy <= 1'b0;
        r_err_wr   <= 1'b0;
      end
      if (w_buf_wr && w_busy) r_err_busy <= 1'b1;
      if ((w_fc1_wr && !w_fc_ok) || i_err_early) r_err_wr <= 1'b1;
      if (w_clr || w_stat_rd) r_done <= 1'b0;
      if (i_done_set) r_done <= 1'b1;
    end
  end

  assign o_buf_sel  = r_buf.sel;
  assign o_buf_idx  = r_buf.idx;
  assign o_buf_data = r_buf.data;
  assign o_irq      = r_done;

endmodule

// File: rtl/npu_seq.sv
// NPU layer sequencer: walks conv1/conv2 per channel, then streams FC1
// weights and waits for the FC result; host access lives in npu_seq_regs.
module npu_seq
  import npu_seq_pkg::*;
#(
  parameter int unsigned NUM_CH     = 10,
  parameter int unsigned CH_W       = 4,
  parameter int unsigned FC1_GROUPS = 33,
  parameter int unsigned GRP_W      = 6,
  parameter int unsigned RES_W      = 24,
  parameter logic [7:0]  VERSION    = 8'h02
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              buf_we,
  output logic [SEL_W-1:0]  buf_sel,
  output logic [IDX_W-1:0]  buf_idx,
  output logic [DATA_W-1:0] buf_data,
  output logic              conv_start,
  output logic              conv_layer,
  input  logic              conv_done,
  output logic              psum_clear,
  output logic              psum_en,
  output logic              fc_start,
  output logic              fc_w_valid,
  input  logic              fc_w_ready,
  input  logic              fc_done,
  input  logic [RES_W-1:0]  fc_logit,
  output logic              irq
);

  state_t             r_state;
  logic [CH_W-1:0]    r_ch_cnt;
  logic [GRP_W-1:0]   r_grp_cnt;
  logic [RES_W-1:0]   r_logit;
  logic               r_conv_start, r_conv_layer, r_psum_clear, r_psum_en, r_fc_start;

  logic               w_go, w_abort, w_new_inf, w_fc_acc;
  logic               w_fc_fin, w_err_early;
  logic [CH_W-1:0]    w_ch_next;
  logic [GRP_W-1:0]   w_grp_next;

  assign w_ch_next   = r_ch_cnt + CH_W'(1);
  assign w_grp_next  = r_grp_cnt + GRP_W'(1);
  // FC result is taken in FC_RUN, or early in FC_STREAM (flagged as error).
  assign w_fc_fin    = fc_done && !w_abort &&
                       ((r_state == ST_FC_RUN) || (r_state == ST_FC_STREAM));
  assign w_err_early = w_fc_fin && (r_state == ST_FC_STREAM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ch_cnt     <= '0;
      r_grp_cnt    <= '0;
      r_logit      <= '0;
      r_conv_start <= 1'b0;
      r_conv_layer <= 1'b0;
      r_psum_clear <= 1'b0;
      r_psum_en    <= 1'b0;
      r_fc_start   <= 1'b0;
    end else begin
      r_conv_start <= 1'b0;
      r_psum_clear <= 1'b0;
      r_fc_start   <= 1'b0;
      if (w_abort) begin
        r_state      <= ST_IDLE;
        r_psum_en    <= 1'b0;
        r_conv_layer <= 1'b0;
        r_ch_cnt     <= '0;
        r_grp_cnt    <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (w_new_inf) begin
            r_psum_clear <= 1'b1;
            r_ch_cnt     <= '0;
            r_state      <= ST_CH_WAIT;
          end
          ST_CH_WAIT: if (w_go) begin
            r_conv_layer <= 1'b0;
            r_conv_start <= 1'b1;
            r_state      <= ST_CONV1;
          end
          ST_CONV1: if (conv_done) r_state <= ST_RELOAD;
          ST_RELOAD: if (w_go) begin
            r_conv_layer <= 1'b1;
            r_psum_en    <= 1'b1;
            r_conv_start <= 1'b1;
            r_state      <= ST_CONV2;
          end
          ST_CONV2: if (conv_done) begin
            r_psum_en <= 1'b0;
            r_ch_cnt  <= w_ch_next;
            r_state   <= (w_ch_next == CH_W'(NUM_CH)) ? ST_FC_START : ST_CH_WAIT;
          end
          ST_FC_START: begin
            r_fc_start <= 1'b1;
            r_grp_cnt  <= '0;
            r_state    <= ST_FC_STREAM;
          end
          ST_FC_STREAM: begin
            if (w_fc_fin) begin
              r_logit <= fc_logit;
              r_state <= ST_IDLE;
            end else if (w_fc_acc) begin
              r_grp_cnt <= w_grp_next;
              if (w_grp_next == GRP_W'(FC1_GROUPS)) r_state <= ST_FC_RUN;
            end
          end
          ST_FC_RUN: if (w_fc_fin) begin
            r_logit <= fc_logit;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign conv_start = r_conv_start;
  assign conv_layer = r_conv_layer;
  assign psum_clear = r_psum_clear;
  assign psum_en    = r_psum_en;
  assign fc_start   = r_fc_start;

  npu_seq_regs #(
    .CH_W    (CH_W),
    .GRP_W   (GRP_W),
    .RES_W   (RES_W),
    .VERSION (VERSION)
  ) u_regs (
    .clk          (clk),
    .rst          (rst),
    .i_ena        (ena),
    .i_wea        (wea),
    .i_addra      (addra),
    .i_dina       (dina),
    .i_state      (r_state),
    .i_ch_cnt     (r_ch_cnt),
    .i_grp_cnt    (r_grp_cnt),
    .i_logit      (r_logit),
    .i_fc_w_ready (fc_w_ready),
    .i_done_set   (w_fc_fin),
    .i_err_early  (w_err_early),
    .o_douta      (douta),
    .o_buf_we     (buf_we),
    .o_buf_sel    (buf_sel),
    .o_buf_idx    (buf_idx),
    .o_buf_data   (buf_data),
    .o_fc_w_valid (fc_w_valid),
    .o_irq        (irq),
    .o_go_c       (w_go),
    .o_abort_c    (w_abort),
    .o_new_inf_c  (w_new_inf),
    .o_fc_acc_c   (w_fc_acc)
  );

endmodule

// File: tb/tb_npu_seq.sv
// Self-checking bench for npu_seq (NUM_CH=2, FC1_GROUPS=3) with randomized
// data, gaps and logits against expectations built from the sequencing rules.
module tb_npu_seq;

  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned CH_W       = 4;
  localparam int unsigned FC1_GROUPS = 3;
  localparam int unsigned GRP_W      = 6;
  localparam int unsigned RES_W      = 24;

  localparam int S_IDLE = 0, S_CONV1 = 2, S_RELOAD = 3, S_STREAM = 6, S_RUN = 7;

  logic              clk = 1'b0;
  logic              rst, ena, wea;
  logic [15:0]       addra;
  logic [31:0]       dina, douta;
  logic              buf_we;
  logic [2:0]        buf_sel;
  logic [11:0]       buf_idx;
  logic [31:0]       buf_data;
  logic              conv_start, conv_layer, conv_done;
  logic              psum_clear, psum_en, fc_start, fc_w_valid, fc_w_ready, fc_done;
  logic [RES_W-1:0]  fc_logit;
  logic              irq;

  int errors = 0;
  int checks = 0;
  int n_cs = 0, n_pc = 0, n_fs = 0, n_wv = 0;

  npu_seq #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .FC1_GROUPS(FC1_GROUPS),
    .GRP_W(GRP_W), .RES_W(RES_W), .VERSION(8'h02)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta), .buf_we(buf_we), .buf_sel(buf_sel), .buf_idx(buf_idx),
    .buf_data(buf_data), .conv_start(conv_start), .conv_layer(conv_layer),
    .conv_done(conv_done), .psum_clear(psum_clear), .psum_en(psum_en),
    .fc_start(fc_start), .fc_w_valid(fc_w_valid), .fc_w_ready(fc_w_ready),
    .fc_done(fc_done), .fc_logit(fc_logit), .irq(irq)
  );

  always #5 clk = ~clk;

  // Pulse counters for the one-cycle strobes.
  always @(posedge clk) begin
    if (conv_start) n_cs <= n_cs + 1;
    if (psum_clear) n_pc <= n_pc + 1;
    if (fc_start)   n_fs <= n_fs + 1;
    if (fc_w_valid) n_wv <= n_wv + 1;
  end

  function automatic logic [31:0] exp_status(input int st, input bit need,
                                             input bit ew, input bit eb, input bit dn);
    return {16'h0000, 8'h02, 4'(st), need, ew, eb, dn};
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic host_wr(input logic [2:0] sel, input logic [11:0] idx, input logic [31:0] d);
    ena = 1'b1; wea = 1'b1; addra = {1'b0, sel, idx}; dina = d;
    cyc();
    ena = 1'b0; wea = 1'b0;
  endtask

  task automatic host_rd(input logic [2:0] sel, input logic [11:0] idx, output logic [31:0] d);
    ena = 1'b1; wea = 1'b0; addra = {1'b0, sel, idx};
    cyc();
    ena = 1'b0;
    d = douta;
  endtask

  task automatic ctrl(input logic [3:0] bits);
    host_wr(3'd5, 12'd0, {28'd0, bits});
  endtask

  task automatic pulse_conv_done;
    conv_done = 1'b1; cyc(); conv_done = 1'b0;
  endtask

  task automatic pulse_fc_done(input int v);
    fc_logit = RES_W'(v); fc_done = 1'b1; cyc(); fc_done = 1'b0;
  endtask

  // Runs NEW_INF plus all conv channels; ends one cycle into FC_START.
  task automatic drive_channels;
    ctrl(4'b1000);
    for (int c = 0; c < int'(NUM_CH); c++) begin
      cyc($urandom_range(0, 2)); ctrl(4'b0001);
      cyc($urandom_range(0, 3)); pulse_conv_done();
      cyc($urandom_range(0, 2)); ctrl(4'b0001);
      cyc($urandom_range(0, 3)); pulse_conv_done();
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1; cyc(3);
    checks++;
    if ({douta, buf_we, conv_start, conv_layer, psum_clear, psum_en, fc_start, fc_w_valid, irq} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs douta=%h irq=%b psum_en=%b expected all 0", douta, irq, psum_en);
    end
    rst = 1'b0; cyc();
    host_rd(3'd7, 12'd0, d);
    checks++;
    if (d !== exp_status(S_IDLE, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_status: got %h expected %h", d, exp_status(S_IDLE, 0, 0, 0, 0));
    end
    host_rd(3'd7, 12'd8, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_counters: got %h expected 0", d); end
  endtask

  task automatic test_read_latency;
    logic [31:0] d;
    host_rd(3'd7, 12'd12, d);
    checks++;
    if (d !== 32'h02) begin errors++; $display("FAIL rd_version: got %h expected 00000002", d); end
    cyc();
    checks++;
    if (douta !== 32'h02) begin errors++; $display("FAIL rd_hold: got %h expected 00000002", douta); end
    host_rd(3'd6, 12'($urandom_range(0, 4095)), d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL rd_unmapped_sel: got %h expected 0", d); end
    host_rd(3'd7, 12'd13, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL rd_unmapped_idx: got %h expected 0", d); end
  endtask

  task automatic test_buf_write;
    logic [2:0]  s;
    logic [11:0] idx;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 2))
        0:       s = 3'd1;
        1:       s = 3'd2;
        default: s = 3'd4;
      endcase
      idx = 12'($urandom_range(0, 4095));
      d   = $urandom;
      host_wr(s, idx, d);
      checks++;
      if ({buf_we, buf_sel, buf_idx, buf_data} !== {1'b1, s, idx, d}) begin
        errors++; $display("FAIL buf_fwd: got we=%b sel=%0d idx=%h data=%h expected we=1 sel=%0d idx=%h data=%h",
                           buf_we, buf_sel, buf_idx, buf_data, s, idx, d);
      end
      cyc();
      checks++;
      if (buf_we !== 1'b0) begin errors++; $display("FAIL buf_we_pulse: got %b expected 0", buf_we); end
    end
  endtask

  task automatic test_full_inference;
    int b_cs, b_pc, b_fs, b_wv;
    logic [31:0] d, wd;
    bit got;
    b_cs = n_cs; b_pc = n_pc; b_fs = n_fs; b_wv = n_wv;
    ctrl(4'b1000);
    checks++;
    if (psum_clear !== 1'b1) begin errors++; $display("FAIL psum_clear: got %b expected 1", psum_clear); end
    for (int c = 0; c < int'(NUM_CH); c++) begin
      ctrl(4'b0001);
      checks++;
      if ({conv_start, conv_layer} !== 2'b10) begin
        errors++; $display("FAIL conv1_start: got start/layer=%b%b expected 10", conv_start, conv_layer);
      end
      cyc($urandom_range(0, 3)); pulse_conv_done();
      host_rd(3'd7, 12'd0, d);
      checks++;
      if (d !== exp_status(S_RELOAD, 0, 0, 0, 0)) begin
        errors++; $display("FAIL reload_status: got %h expected %h", d, exp_status(S_RELOAD, 0, 0, 0, 0));
      end
      ctrl(4'b0001);
      checks++;
      if ({conv_start, conv_layer, psum_en} !== 3'b111) begin
        errors++; $display("FAIL conv2_start: got start/layer/psum_en=%b%b%b expected 111", conv_start, conv_layer, psum_en);
      end
      pulse_conv_done();
      checks++;
      if (psum_en !== 1'b0) begin errors++; $display("FAIL psum_en_off: got %b expected 0", psum_en); end
    end
    got = 0;
    for (int k = 0; k < 4 && !got; k++) begin cyc(); if (fc_start) got = 1; end
    checks++;
    if (!got) begin errors++; $display("FAIL fc_start_wait: got 0 expected 1 within 4 cycles"); end
    fc_w_ready = 1'b1;
    for (int g = 0; g < int'(FC1_GROUPS); g++) begin
      wd = $urandom;
      host_wr(3'd3, 12'(g), wd);
      checks++;
      if ({fc_w_valid, buf_data} !== {1'b1, wd}) begin
        errors++; $display("FAIL fc_w_valid: got valid=%b data=%h expected valid=1 data=%h", fc_w_valid, buf_data, wd);
      end
      if (g == 1) begin
        host_rd(3'd7, 12'd8, d);
        checks++;
        if (d !== 32'((NUM_CH << GRP_W) + 2)) begin
          errors++; $display("FAIL counters_mid: got %h expected %h", d, 32'((NUM_CH << GRP_W) + 2));
        end
      end
    end
    host_rd(3'd7, 12'd0, d);
    checks++;
    if (d !== exp_status(S_RUN, 0, 0, 0, 0)) begin
      errors++; $display("FAIL fc_run_status: got %h expected %h", d, exp_status(S_RUN, 0, 0, 0, 0));
    end
    pulse_fc_done(-5);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", irq); end
    host_rd(3'd7, 12'd4, d);
    checks++;
    if (d !== 32'hFFFF_FFFB) begin errors++; $display("FAIL logit_neg5: got %h expected fffffffb", d); end
    checks++;
    if ({n_cs - b_cs, n_pc - b_pc, n_fs - b_fs, n_wv - b_wv} !== {32'd4, 32'd1, 32'd1, 32'd3}) begin
      errors++; $display("FAIL pulse_counts: got cs=%0d pc=%0d fs=%0d wv=%0d expected 4 1 1 3",
                         n_cs - b_cs, n_pc - b_pc, n_fs - b_fs, n_wv - b_wv);
    end
    host_rd(3'd7, 12'd0, d);
    checks++;
    if (d !== exp_status(S_IDLE, 0, 0, 0, 1)) begin
      errors++; $display("FAIL done_read1: got %h expected %h", d, exp_status(S_IDLE, 0, 0, 0, 1));
    end
    host_rd(3'd7, 12'd0, d);
    checks++;
    if (d !== exp_status(S_IDLE, 0, 0, 0, 0)) begin
      errors++; $display("FAIL done_read2: got %h expected %h", d, exp_status(S_IDLE, 0, 0, 0, 0));
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
    fc_w_ready = 1'b0;
  endtask

  task automatic test_busy_write;
    logic [31:0] d;
    ctrl(4'b1000); ctrl(4'b0001);
    host_wr(3'd1, 12'($urandom_range(0, 4095)), $urandom);
    checks++;
    if (buf_we !== 1'b0) begin errors++; $display("FAIL busy_drop: got buf_we=%b expected 0", buf_we); end
    host_rd(3'd7, 12'd0, d);
    checks++;
    if (d !== exp_status(S_CONV1, 0, 0, 1, 0)) begin
      errors++; $display("FAIL err_busy_set: got %h expected %h", d, exp_status(S_CONV1, 0, 0, 1, 0));
    end
    ctrl(4'b0100);
    host_rd(3'd7, 12'd0, d);
    checks++;
    if (d !== exp_status(S_CONV1, 0, 0, 0, 0)) begin
      errors++; $display("FAIL err_busy_clr: got %h expected %h", d, exp_status(S_CONV1, 0, 0, 0, 0));
    end
    ctrl(4'b0010);
  endtask

  task automatic test_abort_conv2;
    logic [31:0] d;
    ctrl(4'b1000);
    ctrl(4'b0001); pulse_conv_done(); ctrl(4'b0001); pulse_conv_done();
    ctrl(4'b0001); pulse_conv_done(); ctrl(4'b0001);
    checks++;
    if (psum_en !== 1'b1) begin errors++; $display("FAIL abort_pre_psum: got %b expected 1", psum_en); end
    ena = 1'b1; wea = 1'b1; addra = {4'h5, 12'h000}; dina = 32'h2; conv_done = 1'b1;
    cyc();
    ena = 1'b0; wea = 1'b0; conv_done = 1'b0;
    checks++;
    if (psum_en !== 1'b0) begin errors++; $display("FAIL abort_psum_en: got %b expected 0", psum_en); end
    host_rd(3'd7, 12'd0, d);
    checks++;
    if (d !== exp_status(S_IDLE, 0, 0, 0, 0)) begin
      errors++; $display("FAIL abort_state: got %h expected %h", d, exp_status(S_IDLE, 0, 0, 0, 0));
    end
    host_rd(3'd7, 12'd8, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL abort_counters: got %h expected 0", d); end
  endtask

  task automatic test_wr_not_ready;
    logic [31:0] d;
    int v;
    v = int'($urandom_range(0, 32'hFF_FFFF)) - 32'h80_0000;
    fc_w_ready = 1'b0;
    drive_channels(); cyc(2);
    host_rd(3'd7, 12'd0, d);
    checks++;
    if (d !== exp_status(S_STREAM, 0, 0, 0, 0)) begin
      errors++; $display("FAIL stream_status: got %h expected %h", d, exp_status(S_STREAM, 0, 0, 0, 0));
    end
    host_wr(3'd3, 12'd0, $urandom);
    checks++;
    if (fc_w_valid !== 1'b0) begin errors++; $display("FAIL nready_valid: got %b expected 0", fc_w_valid); end
    host_rd(3'd7, 12'd0, d);
    checks++;
    if (d !== exp_status(S_STREAM, 0, 1, 0, 0)) begin
      errors++; $display("FAIL err_wr_set: got %h expected %h", d, exp_status(S_STREAM, 0, 1, 0, 0));
    end
    host_rd(3'd7, 12'd8, d);
    checks++;
    if (d !== 32'(NUM_CH << GRP_W)) begin errors++; $display("FAIL grp_unchanged: got %h expected %h", d, 32'(NUM_CH << GRP_W)); end
    fc_w_ready = 1'b1;
    host_rd(3'd7, 12'd0, d);
    checks++;
    if (d !== exp_status(S_STREAM, 1, 1, 0, 0)) begin
      errors++; $display("FAIL need_w: got %h expected %h", d, exp_status(S_STREAM, 1, 1, 0, 0));
    end
    host_wr(3'd3, 12'd0, $urandom);
    host_rd(3'd7, 12'd8, d);
    checks++;
    if (d !== 32'((NUM_CH << GRP_W) + 1)) begin errors++; $display("FAIL grp_inc: got %h expected %h", d, 32'((NUM_CH << GRP_W) + 1)); end
    pulse_fc_done(v);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL early_irq: got %b expected 1", irq); end
    host_rd(3'd7, 12'd0, d);
    checks++;
    if (d !== exp_status(S_IDLE, 0, 1, 0, 1)) begin
      errors++; $display("FAIL early_status: got %h expected %h", d, exp_status(S_IDLE, 0, 1, 0, 1));
    end
    host_rd(3'd7, 12'd4, d);
    checks++;
    if (d !== 32'(v)) begin errors++; $display("FAIL early_logit: got %h expected %h", d, 32'(v)); end
    ctrl(4'b0100);
    fc_w_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    int v, b_cs;
    for (int it = 0; it < 3; it++) begin
      v = int'($urandom_range(0, 32'hFF_FFFF)) - 32'h80_0000;
      b_cs = n_cs;
      ctrl(4'b0001);
      checks++;
      if (conv_start !== 1'b0) begin errors++; $display("FAIL idle_go_ignored: got %b expected 0", conv_start); end
      drive_channels(); cyc(2);
      fc_w_ready = 1'b1;
      for (int g = 0; g < int'(FC1_GROUPS); g++) begin
        cyc($urandom_range(0, 2)); host_wr(3'd3, 12'(g), $urandom);
      end
      cyc($urandom_range(0, 3)); pulse_fc_done(v);
      fc_w_ready = 1'b0;
      host_rd(3'd7, 12'd4, d);
      checks++;
      if (d !== 32'(v)) begin errors++; $display("FAIL b2b_logit[%0d]: got %h expected %h", it, d, 32'(v)); end
      host_rd(3'd7, 12'd0, d);
      checks++;
      if (d !== exp_status(S_IDLE, 0, 0, 0, 1)) begin
        errors++; $display("FAIL b2b_status[%0d]: got %h expected %h", it, d, exp_status(S_IDLE, 0, 0, 0, 1));
      end
      checks++;
      if (n_cs - b_cs != 4) begin errors++; $display("FAIL b2b_conv_starts[%0d]: got %0d expected 4", it, n_cs - b_cs); end
    end
  endtask

  task automatic test_midreset;
    logic [31:0] d;
    ctrl(4'b1000); ctrl(4'b0001); pulse_conv_done(); ctrl(4'b0001);
    host_wr(3'd2, 12'd5, $urandom);
    rst = 1'b1; cyc(); rst = 1'b0;
    checks++;
    if ({psum_en, conv_layer, irq} !== 3'b000) begin
      errors++; $display("FAIL midreset_out: got psum_en/layer/irq=%b%b%b expected 000", psum_en, conv_layer, irq);
    end
    host_rd(3'd7, 12'd0, d);
    checks++;
    if (d !== exp_status(S_IDLE, 0, 0, 0, 0)) begin
      errors++; $display("FAIL midreset_status: got %h expected %h", d, exp_status(S_IDLE, 0, 0, 0, 0));
    end
    host_rd(3'd7, 12'd4, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL midreset_logit: got %h expected 0", d); end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; wea = 1'b0; addra = '0; dina = '0;
    conv_done = 1'b0; fc_w_ready = 1'b0; fc_done = 1'b0; fc_logit = '0;
    test_reset();
    test_read_latency();
    test_buf_write();
    test_full_inference();
    test_busy_write();
    test_abort_conv2();
    test_wr_not_ready();
    test_back_to_back();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
